// File: rtl/imem_fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : imem_fetch_pkg
// Description : Shared types and constants for the Y86 instruction-memory
//               fetch sequencer: FSM state encoding, icode values, maximum
//               instruction length and the icode -> length lookup.
// Revision    : 1.0 - initial release
// ============================================================================
package imem_fetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam int INSTR_BYTES = 10;

    localparam logic [3:0] ICODE_HALT   = 4'h0;
    localparam logic [3:0] ICODE_NOP    = 4'h1;
    localparam logic [3:0] ICODE_RRMOVQ = 4'h2;
    localparam logic [3:0] ICODE_IRMOVQ = 4'h3;
    localparam logic [3:0] ICODE_RMMOVQ = 4'h4;
    localparam logic [3:0] ICODE_MRMOVQ = 4'h5;
    localparam logic [3:0] ICODE_OPQ    = 4'h6;
    localparam logic [3:0] ICODE_JXX    = 4'h7;
    localparam logic [3:0] ICODE_CALL   = 4'h8;
    localparam logic [3:0] ICODE_RET    = 4'h9;
    localparam logic [3:0] ICODE_PUSHQ  = 4'hA;
    localparam logic [3:0] ICODE_POPQ   = 4'hB;

    // Instruction length in bytes for a given icode; unknown icodes are
    // treated as single-byte so the fetch never over-runs.
    function automatic logic [3:0] icode_len(input logic [3:0] icode);
        logic [3:0] len;
        case (icode)
            ICODE_HALT, ICODE_NOP, ICODE_RET:                   len = 4'd1;
            ICODE_RRMOVQ, ICODE_OPQ, ICODE_PUSHQ, ICODE_POPQ:   len = 4'd2;
            ICODE_JXX, ICODE_CALL:                              len = 4'd9;
            ICODE_IRMOVQ, ICODE_RMMOVQ, ICODE_MRMOVQ:           len = 4'd10;
            default:                                            len = 4'd1;
        endcase
        return len;
    endfunction

endpackage
`default_nettype wire

// File: rtl/instr_len_decode.sv
`default_nettype none
// ============================================================================
// Module      : instr_len_decode
// Description : Combinational Y86 instruction-length decoder (icode -> bytes).
// Ports       : i_icode [3:0] - icode field (Byte0[7:4])
//               o_len   [3:0] - instruction length, 1..10
// Revision    : 1.0 - initial release
// ============================================================================
module instr_len_decode
    import imem_fetch_pkg::*;
(
    input  logic [3:0] i_icode,
    output logic [3:0] o_len
);

    assign o_len = icode_len(i_icode);

endmodule
`default_nettype wire

// File: rtl/imem_fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : imem_fetch_sequencer
// Description : Drives a byte-wide, 1-cycle-latency synchronous instruction
//               memory to assemble one Y86 instruction window (Byte0 plus
//               Byte1..9). Flags out-of-range PCs and supports flush.
// Config      : IMEM_FETCH_LEN_DECODE_EN - when defined, the fetch length is
//               decoded from Byte0 and issue stops early; otherwise all 10
//               bytes are always fetched.
// Ports       : clk, rst_n           - clock, async active-low reset
//               i_req_valid/o_req_ready/i_req_pc - fetch request
//               i_flush              - abort fetch, back to IDLE
//               o_mem_rd_en/o_mem_addr/i_mem_rdata - memory interface
//               o_rsp_valid/i_rsp_ready - window handshake
//               o_rsp_byte0, o_rsp_byte19, o_rsp_len, o_imem_error - window
// Revision    : 1.0 - initial release
// ============================================================================
module imem_fetch_sequencer
    import imem_fetch_pkg::*;
#(
    parameter int MEM_DEPTH = 2048,
    parameter int ADDR_W    = 11
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic [63:0]       i_req_pc,
    input  logic              i_flush,
    output logic              o_mem_rd_en,
    output logic [ADDR_W-1:0] o_mem_addr,
    input  logic [7:0]        i_mem_rdata,
    output logic              o_rsp_valid,
    input  logic              i_rsp_ready,
    output logic [7:0]        o_rsp_byte0,
    output logic [71:0]       o_rsp_byte19,
    output logic [3:0]        o_rsp_len,
    output logic              o_imem_error
);

    state_t r_state;
    state_t w_state_next;

    logic [63:0]                     r_pc;
    logic [INSTR_BYTES-1:0][7:0]     r_buf;
    logic [3:0]                      r_len;      // best-known fetch length
    logic [3:0]                      r_rsp_len;
    logic                            r_err;
    // Issue stage: the read presented to memory in the current cycle.
    logic                            r_iss_act;  // slot issued (real or past-end)
    logic [3:0]                      r_iss_idx;
    logic                            r_rd_en;    // real memory read
    logic [ADDR_W-1:0]               r_addr;
    // Capture stage: the issue from last cycle whose data is on i_mem_rdata.
    logic                            r_tok;
    logic [3:0]                      r_tok_idx;
    logic                            r_tok_rd;

    logic        w_accept;
    logic        w_pc_bad;
    logic        w_pc1_ok;
    logic [63:0] w_pc1;
    logic [3:0]  w_len_dec;
    logic [3:0]  w_len_eff;
    logic        w_last;
    logic        w_next_iss_ok;
    logic [63:0] w_next_addr;
    logic        w_next_in_range;

    // Gating with rst_n keeps the request side quiet while reset is held.
    assign o_req_ready = (r_state == ST_IDLE) && rst_n;
    assign w_accept    = i_req_valid && o_req_ready;
    assign w_pc_bad    = i_req_pc > 64'(MEM_DEPTH - 1);
    assign w_pc1       = i_req_pc + 64'd1;
    assign w_pc1_ok    = w_pc1 < 64'(MEM_DEPTH);

`ifdef IMEM_FETCH_LEN_DECODE_EN
    instr_len_decode u_len_decode (
        .i_icode (i_mem_rdata[7:4]),
        .o_len   (w_len_dec)
    );
`else
    assign w_len_dec = 4'(INSTR_BYTES);
`endif

    // Byte0 arrives with token 0; from that edge on its decoded length rules.
    assign w_len_eff       = (r_tok && (r_tok_idx == 4'd0)) ? w_len_dec : r_len;
    assign w_last          = r_tok && (r_tok_idx == (w_len_eff - 4'd1));
    assign w_next_iss_ok   = r_iss_act && ((r_iss_idx + 4'd1) < w_len_eff);
    assign w_next_addr     = r_pc + 64'(r_iss_idx) + 64'd1;
    assign w_next_in_range = w_next_addr < 64'(MEM_DEPTH);

    // Issue 0 goes out in the accepting cycle so Byte0 is back one cycle later.
    assign o_mem_rd_en = (w_accept && !w_pc_bad) || r_rd_en;
    assign o_mem_addr  = w_accept ? i_req_pc[ADDR_W-1:0] : r_addr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_next = w_pc_bad ? ST_RESP : ST_READ;
                end
            end
            ST_READ: begin
                if (i_flush) begin
                    w_state_next = ST_IDLE;
                end else if (w_last) begin
                    w_state_next = ST_RESP;
                end
            end
            ST_RESP: begin
                if (i_flush || i_rsp_ready) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc      <= '0;
            r_buf     <= '0;
            r_len     <= '0;
            r_rsp_len <= '0;
            r_err     <= 1'b0;
            r_iss_act <= 1'b0;
            r_iss_idx <= '0;
            r_rd_en   <= 1'b0;
            r_addr    <= '0;
            r_tok     <= 1'b0;
            r_tok_idx <= '0;
            r_tok_rd  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_pc      <= i_req_pc;
                        r_buf     <= '0;
                        r_err     <= w_pc_bad;
                        r_rsp_len <= '0;
                        r_len     <= 4'(INSTR_BYTES);
                        r_tok     <= !w_pc_bad;
                        r_tok_idx <= '0;
                        r_tok_rd  <= !w_pc_bad;
                        r_iss_act <= !w_pc_bad;
                        r_iss_idx <= 4'd1;
                        r_rd_en   <= !w_pc_bad && w_pc1_ok;
                        r_addr    <= w_pc1[ADDR_W-1:0];
                    end
                end
                ST_READ: begin
                    if (i_flush) begin
                        r_iss_act <= 1'b0;
                        r_rd_en   <= 1'b0;
                        r_tok     <= 1'b0;
                    end else begin
                        r_tok     <= r_iss_act;
                        r_tok_idx <= r_iss_idx;
                        r_tok_rd  <= r_rd_en;
                        r_len     <= w_len_eff;
                        // Past-end slots stay at the zero left by accept.
                        if (r_tok && r_tok_rd) begin
                            r_buf[r_tok_idx] <= i_mem_rdata;
                        end
                        if (w_last) begin
                            r_iss_act <= 1'b0;
                            r_rd_en   <= 1'b0;
                            r_tok     <= 1'b0;
                            r_rsp_len <= w_len_eff;
                        end else if (w_next_iss_ok) begin
                            r_iss_idx <= r_iss_idx + 4'd1;
                            r_rd_en   <= w_next_in_range;
                            r_addr    <= w_next_addr[ADDR_W-1:0];
                        end else begin
                            r_iss_act <= 1'b0;
                            r_rd_en   <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_iss_act <= 1'b0;
                    r_rd_en   <= 1'b0;
                    r_tok     <= 1'b0;
                end
            endcase
        end
    end

    assign o_rsp_valid  = (r_state == ST_RESP);
    assign o_rsp_byte0  = r_buf[0];
    assign o_rsp_len    = r_rsp_len;
    assign o_imem_error = r_err;

    // pc+1 lands in the top byte, pc+9 in the bottom byte.
    for (genvar k = 1; k < INSTR_BYTES; k++) begin : g_pack
        assign o_rsp_byte19[8*(INSTR_BYTES-1-k) +: 8] = r_buf[k];
    end

endmodule
`default_nettype wire

// File: tb/tb_imem_fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_imem_fetch_sequencer
// Description : Self-checking bench for imem_fetch_sequencer with a byte
//               memory model and a window-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_fetch_sequencer;

    localparam int MEM_DEPTH = 2048;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [63:0] req_pc = '0;
    logic        flush = 1'b0;
    logic        mem_rd_en;
    logic [10:0] mem_addr;
    logic [7:0]  mem_rdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [7:0]  rsp_byte0;
    logic [71:0] rsp_byte19;
    logic [3:0]  rsp_len;
    logic        imem_error;

    logic [7:0]  mem [MEM_DEPTH];
    int          total = 0;
    int          bad = 0;
    int          rd_count = 0;

    imem_fetch_sequencer #(.MEM_DEPTH(MEM_DEPTH), .ADDR_W(11)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_req_valid  (req_valid),
        .o_req_ready  (req_ready),
        .i_req_pc     (req_pc),
        .i_flush      (flush),
        .o_mem_rd_en  (mem_rd_en),
        .o_mem_addr   (mem_addr),
        .i_mem_rdata  (mem_rdata),
        .o_rsp_valid  (rsp_valid),
        .i_rsp_ready  (rsp_ready),
        .o_rsp_byte0  (rsp_byte0),
        .o_rsp_byte19 (rsp_byte19),
        .o_rsp_len    (rsp_len),
        .o_imem_error (imem_error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_rd_en) begin
            mem_rdata <= mem[mem_addr];
            rd_count  = rd_count + 1;
        end
    end

    task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int tb_len(input logic [7:0] b);
        int n;
`ifdef IMEM_FETCH_LEN_DECODE_EN
        case (b[7:4])
            4'h0, 4'h1, 4'h9:       n = 1;
            4'h2, 4'h6, 4'hA, 4'hB: n = 2;
            4'h7, 4'h8:             n = 9;
            4'h3, 4'h4, 4'h5:       n = 10;
            default:                n = 1;
        endcase
`else
        n = 10;
`endif
        return n;
    endfunction

    // Window a correct fetch of pc must return, derived from memory contents.
    task automatic model(input logic [63:0] pc, output logic [7:0] b0, output logic [71:0] b19,
                         output logic [3:0] len, output logic err, output int lat);
        int L;
        logic [7:0] w;
        b0 = '0; b19 = '0; len = '0; err = 1'b0; lat = 1;
        if (pc > 64'(MEM_DEPTH - 1)) begin
            err = 1'b1;
        end else begin
            L = tb_len(mem[int'(pc)]);
            for (int i = 0; i < 10; i++) begin
                w = (i < L && int'(pc) + i < MEM_DEPTH) ? mem[int'(pc) + i] : 8'h00;
                if (i == 0) b0 = w;
                else b19 = {b19[63:0], w};
            end
            len = 4'(L);
            lat = L + 1;
        end
    endtask

    task automatic do_fetch(input logic [63:0] pc, input string tag);
        logic [7:0]  eb0;
        logic [71:0] eb19;
        logic [3:0]  elen;
        logic        eerr;
        int          elat;
        int          lat;
        int          rc0;
        model(pc, eb0, eb19, elen, eerr, elat);
        @(negedge clk);
        check({tag, ":req_ready"}, 80'(req_ready), 80'(1));
        req_pc = pc;
        req_valid = 1'b1;
        rc0 = rd_count;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 30) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, ":latency"}, 80'(lat), 80'(elat));
        check({tag, ":imem_error"}, 80'(imem_error), 80'(eerr));
        check({tag, ":byte0"}, 80'(rsp_byte0), 80'(eb0));
        check({tag, ":byte19"}, 80'(rsp_byte19), 80'(eb19));
        check({tag, ":len"}, 80'(rsp_len), 80'(elen));
        if (eerr) check({tag, ":no_reads"}, 80'(rd_count), 80'(rc0));
        if (rsp_ready) begin
            @(posedge clk);
            #1;
            check({tag, ":consumed"}, 80'({rsp_valid, req_ready}), 80'(2'b01));
        end
    endtask

    initial begin
        logic [7:0]  s_b0;
        logic [71:0] s_b19;
        logic [3:0]  s_len;
        logic        seen;
        logic [63:0] pc;

        for (int i = 0; i < MEM_DEPTH; i++) mem[i] = 8'($urandom);
        for (int i = 0; i < 10; i++) mem[i] = 8'h00;
        mem[0] = 8'h30; mem[1] = 8'hF8; mem[2] = 8'h08;
        for (int i = 10; i < 20; i++) mem[i] = 8'h00;
        mem[10] = 8'h30; mem[11] = 8'hF7; mem[12] = 8'h0A;
        mem[154] = 8'h90;

        // Reset values
        repeat (2) @(negedge clk);
        check("reset:outs", 80'({rsp_valid, mem_rd_en, imem_error, rsp_len, req_ready}), 80'(0));
        check("reset:bytes", 80'({rsp_byte0, rsp_byte19}), 80'(0));
        check("reset:addr", 80'(mem_addr), 80'(0));
        rst_n = 1'b1;
        #1;
        check("reset:ready", 80'(req_ready), 80'(1));

        // irmovq at 0
        do_fetch(64'd0, "irmovq");
        check("irmovq:b0_const", 80'(rsp_byte0), 80'(8'h30));
        check("irmovq:b19_const", 80'(rsp_byte19), 80'(72'hF8_08_00_00_00_00_00_00_00));
        check("irmovq:len_const", 80'(rsp_len), 80'(10));

        // Out-of-range PCs
        do_fetch(64'd2048, "oor2048");
        do_fetch(64'hFFFF_FFFF_FFFF_FFFF, "oor_max");

        // Straddling the top of memory
        do_fetch(64'd2045, "pc2045");
        do_fetch(64'd2047, "pc2047");

        // Flush in cycle 4 of a fetch
        @(negedge clk);
        req_pc = 64'd0;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush:idle", 80'({req_ready, rsp_valid}), 80'(2'b10));
        seen = 1'b0;
        repeat (15) begin
            @(posedge clk);
            #1;
            if (rsp_valid) seen = 1'b1;
        end
        check("flush:no_rsp", 80'(seen), 80'(0));
        do_fetch(64'd10, "after_flush");
        check("after_flush:bytes", 80'({rsp_byte0, rsp_byte19[71:56]}), 80'(24'h30_F7_0A));

        // ret at 154
        do_fetch(64'd154, "ret");
`ifdef IMEM_FETCH_LEN_DECODE_EN
        check("ret:len_const", 80'(rsp_len), 80'(1));
        check("ret:b19_const", 80'(rsp_byte19), 80'(0));
`else
        check("ret:len_const", 80'(rsp_len), 80'(10));
`endif

        // Backpressure: hold rsp_ready low for 5 cycles
        rsp_ready = 1'b0;
        do_fetch(64'd500, "hold");
        s_b0 = rsp_byte0;
        s_b19 = rsp_byte19;
        s_len = rsp_len;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("hold:valid_ready", 80'({rsp_valid, req_ready}), 80'(2'b10));
            check("hold:stable", 80'({rsp_byte0, rsp_byte19}), 80'({s_b0, s_b19}));
            check("hold:len", 80'(rsp_len), 80'(s_len));
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        check("hold:consumed", 80'({rsp_valid, req_ready}), 80'(2'b01));

        // Reset asserted mid-fetch
        @(negedge clk);
        req_pc = 64'd0;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midreset:outs", 80'({rsp_valid, mem_rd_en, imem_error, rsp_len}), 80'(0));
        check("midreset:bytes", 80'({rsp_byte0, rsp_byte19}), 80'(0));
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("midreset:ready", 80'(req_ready), 80'(1));
        seen = 1'b0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (rsp_valid) seen = 1'b1;
        end
        check("midreset:no_rsp", 80'(seen), 80'(0));

        // Randomized fetches
        for (int n = 0; n < 25; n++) begin
            if ($urandom_range(0, 99) < 10) pc = 64'(2048 + $urandom_range(0, 40));
            else pc = 64'($urandom_range(0, MEM_DEPTH - 1));
            do_fetch(pc, "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
